// File: rtl/ts_pkg.sv
// ts_pkg: constants and FSM state type shared by the TS sync/lock slice.
//   TS_SYNC_BYTE  MPEG-2 TS sync byte value
//   TS_LEN_188    plain TS packet length
//   TS_LEN_204    RS-coded TS packet length
//   ts_state_e    sync FSM states (HUNT, VERIFY, LOCKED)
package ts_pkg;

   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam int         TS_LEN_188   = 188;
   localparam int         TS_LEN_204   = 204;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } ts_state_e;

endpackage

// File: rtl/ts_pos_counter.sv
// ts_pos_counter: byte position inside a TS packet, counted in valid bytes.
//   clk       clock, rising edge
//   rst       synchronous active-high reset (pos -> 0)
//   en        advance qualifier (byte_valid); nothing changes while low
//   clr       force pos to 0 on an enabled byte
//   load1     force pos to 1 on an enabled byte (sync byte just seen at 0)
//   pos       current position, 0..PKT_LEN-1
//   at_start  pos == 0 (sync byte slot)
//   at_end    pos == PKT_LEN-1 (last byte of packet)
module ts_pos_counter
   import ts_pkg::*;
#(
   parameter int PKT_LEN = TS_LEN_188,
   parameter int POS_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load1,
   output logic [POS_W-1:0] pos,
   output logic             at_start,
   output logic             at_end
);

   assign at_start = (pos == '0);
   assign at_end   = (pos == POS_W'(PKT_LEN - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         pos <= '0;
      end else if (en) begin
         if (clr)         pos <= '0;
         else if (load1)  pos <= POS_W'(1);
         else if (at_end) pos <= '0;
         else             pos <= pos + POS_W'(1);
      end
   end

endmodule

// File: rtl/ts_sync_lock.sv
// ts_sync_lock: single-channel MPEG-2 TS sync acquisition with flywheel lock.
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   byte_in       stream byte
//   byte_valid    byte_in qualifier; all state advances only on valid bytes
//   byte_out      registered byte_in (0 when not valid)
//   valid         registered byte_valid
//   sync          byte_out is a packet start while locked
//   locked        lock status aligned with byte_out (holds across gaps)
//   pkt_end       byte_out is the last byte of a locked packet
//   sync_err      pulse: sync slot held a non-sync byte while locked
//   lock_lost     pulse: lock dropped on this byte
//   sync_err_cnt  saturating count of sync_err pulses
module ts_sync_lock
   import ts_pkg::*;
#(
   parameter int         PKT_LEN      = TS_LEN_188,
   parameter logic [7:0] SYNC_BYTE    = TS_SYNC_BYTE,
   parameter int         LOCK_COUNT   = 5,
   parameter int         UNLOCK_COUNT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic [7:0]  byte_out,
   output logic        valid,
   output logic        sync,
   output logic        locked,
   output logic        pkt_end,
   output logic        sync_err,
   output logic        lock_lost,
   output logic [15:0] sync_err_cnt
);

   localparam int POS_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT + 1) : 1;

   ts_state_e          state, state_nxt;
   logic [GOOD_W-1:0]  good, good_nxt, good_inc;
   logic [MISS_W-1:0]  miss, miss_nxt, miss_inc;
   logic [POS_W-1:0]   pos;
   logic               at_start, at_end;
   logic               pos_clr, pos_load1;
   logic               is_sync;
   logic               sync_d, pkt_end_d, err_d, lost_d;

   ts_pos_counter #(
      .PKT_LEN (PKT_LEN),
      .POS_W   (POS_W)
   ) u_pos (
      .clk      (clk),
      .rst      (rst),
      .en       (byte_valid),
      .clr      (pos_clr),
      .load1    (pos_load1),
      .pos      (pos),
      .at_start (at_start),
      .at_end   (at_end)
   );

   assign is_sync  = (byte_in == SYNC_BYTE);
   assign good_inc = good + GOOD_W'(1);
   assign miss_inc = miss + MISS_W'(1);

   // State register (with its good/miss counters)
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
         good  <= '0;
         miss  <= '0;
      end else if (byte_valid) begin
         state <= state_nxt;
         good  <= good_nxt;
         miss  <= miss_nxt;
      end
   end

   // Next state and per-byte flags. Everything is gated by byte_valid so
   // idle cycles leave the FSM, counters and position untouched.
   always_comb begin
      state_nxt = state;
      good_nxt  = good;
      miss_nxt  = miss;
      pos_clr   = 1'b0;
      pos_load1 = 1'b0;
      sync_d    = 1'b0;
      pkt_end_d = 1'b0;
      err_d     = 1'b0;
      lost_d    = 1'b0;
      if (byte_valid) begin
         case (state)
            HUNT: begin
               if (is_sync) begin
                  pos_load1 = 1'b1;
                  good_nxt  = GOOD_W'(1);
                  state_nxt = VERIFY;
               end else begin
                  pos_clr = 1'b1;
               end
            end
            VERIFY: begin
               if (at_start) begin
                  if (is_sync) begin
                     if (good_inc == GOOD_W'(LOCK_COUNT)) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                        miss_nxt  = '0;
                        sync_d    = 1'b1;
                     end else begin
                        good_nxt = good_inc;
                     end
                  end else begin
                     // mismatching byte is consumed, not retried as a candidate
                     state_nxt = HUNT;
                     good_nxt  = '0;
                     pos_clr   = 1'b1;
                  end
               end
            end
            LOCKED: begin
               pkt_end_d = at_end;
               if (at_start) begin
                  if (is_sync) begin
                     miss_nxt = '0;
                     sync_d   = 1'b1;
                  end else if (miss_inc == MISS_W'(UNLOCK_COUNT)) begin
                     state_nxt = HUNT;
                     miss_nxt  = '0;
                     err_d     = 1'b1;
                     lost_d    = 1'b1;
                     pos_clr   = 1'b1;
                  end else begin
                     // flywheel: keep flagging the expected packet start
                     miss_nxt = miss_inc;
                     sync_d   = 1'b1;
                     err_d    = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = HUNT;
               good_nxt  = '0;
               miss_nxt  = '0;
               pos_clr   = 1'b1;
            end
         endcase
      end
   end

   // Registered outputs, one cycle behind byte_in
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_out     <= '0;
         valid        <= 1'b0;
         sync         <= 1'b0;
         locked       <= 1'b0;
         pkt_end      <= 1'b0;
         sync_err     <= 1'b0;
         lock_lost    <= 1'b0;
         sync_err_cnt <= '0;
      end else begin
         byte_out  <= byte_valid ? byte_in : 8'h00;
         valid     <= byte_valid;
         sync      <= sync_d;
         pkt_end   <= pkt_end_d;
         sync_err  <= err_d;
         lock_lost <= lost_d;
         if (byte_valid)
            locked <= (state_nxt == LOCKED);
         if (err_d && (sync_err_cnt != 16'hFFFF))
            sync_err_cnt <= sync_err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ts_sync_lock.sv
// tb_ts_sync_lock: directed bench for ts_sync_lock. Two instances share the
// input stream: u_a configured for 188-byte packets, u_b for 204-byte.
module tb_ts_sync_lock;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] byte_in;
   logic       byte_valid;

   logic [7:0]  a_byte_out, b_byte_out;
   logic        a_valid, a_sync, a_locked, a_pkt_end, a_sync_err, a_lock_lost;
   logic        b_valid, b_sync, b_locked, b_pkt_end, b_sync_err, b_lock_lost;
   logic [15:0] a_cnt, b_cnt;

   int total = 0;
   int bad   = 0;
   int gap_max = 0;
   int gap_bad = 0;

   // per-packet captures
   logic       c_a_sync, c_a_lock, c_a_err, c_a_lost, c_a_end, c_a_mid;
   logic       c_b_sync, c_b_lock, c_b_end, c_b_mid;
   logic [7:0] c_a_bo;

   always #5 clk = ~clk;

   ts_sync_lock #(.PKT_LEN(188)) u_a (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_out(a_byte_out), .valid(a_valid), .sync(a_sync), .locked(a_locked),
      .pkt_end(a_pkt_end), .sync_err(a_sync_err), .lock_lost(a_lock_lost),
      .sync_err_cnt(a_cnt)
   );

   ts_sync_lock #(.PKT_LEN(204)) u_b (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_out(b_byte_out), .valid(b_valid), .sync(b_sync), .locked(b_locked),
      .pkt_end(b_pkt_end), .sync_err(b_sync_err), .lock_lost(b_lock_lost),
      .sync_err_cnt(b_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One valid byte, optionally preceded by random idle cycles; outputs are
   // sampled 1 time unit after the edge that registers the byte.
   task automatic send_byte(input logic [7:0] b);
      int   g;
      logic lk;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      lk = a_locked;
      for (int k = 0; k < g; k++) begin
         byte_valid = 1'b0;
         byte_in    = 8'hFF;
         @(posedge clk); #1;
         if (a_valid !== 1'b0 || a_byte_out !== 8'h00 || a_sync !== 1'b0 ||
             a_pkt_end !== 1'b0 || a_sync_err !== 1'b0 || a_lock_lost !== 1'b0 ||
             a_locked !== lk)
            gap_bad++;
      end
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   // Filler never equals 0x47 (range 1..64).
   task automatic send_pkt(input int len, input logic [7:0] first);
      send_byte(first);
      c_a_sync = a_sync;   c_a_lock = a_locked; c_a_err = a_sync_err;
      c_a_lost = a_lock_lost; c_a_bo = a_byte_out;
      c_b_sync = b_sync;   c_b_lock = b_locked;
      c_a_mid = 1'b0; c_b_mid = 1'b0; c_a_end = 1'b0; c_b_end = 1'b0;
      for (int i = 1; i < len; i++) begin
         send_byte(8'((i % 64) + 1));
         if (i == len - 1) begin
            c_a_end = a_pkt_end;
            c_b_end = b_pkt_end;
         end else begin
            c_a_mid = c_a_mid | a_pkt_end | a_sync | a_sync_err;
            c_b_mid = c_b_mid | b_pkt_end | b_sync | b_sync_err;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; byte_valid = 1'b1; byte_in = 8'h47;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; byte_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0;

      // reset state (rst dominates a valid sync byte)
      do_reset();
      check("rst_a_valid",   a_valid, 0);
      check("rst_a_byteout", a_byte_out, 0);
      check("rst_a_sync",    a_sync, 0);
      check("rst_a_locked",  a_locked, 0);
      check("rst_a_pkt_end", a_pkt_end, 0);
      check("rst_a_err",     a_sync_err, 0);
      check("rst_a_lost",    a_lock_lost, 0);
      check("rst_a_cnt",     a_cnt, 0);
      check("rst_b_locked",  b_locked, 0);

      // junk before the stream: passthrough, no lock
      send_byte(8'h10);
      check("junk_valid",   a_valid, 1);
      check("junk_byteout", a_byte_out, 8'h10);
      check("junk_locked",  a_locked, 0);

      // clean 188 stream: u_a locks on the 5th sync, u_b never locks
      for (int p = 0; p < 7; p++) begin
         send_pkt(188, 8'h47);
         check($sformatf("a188_sync_p%0d", p), c_a_sync, (p >= 4));
         check($sformatf("a188_lock_p%0d", p), c_a_lock, (p >= 4));
         check($sformatf("a188_end_p%0d", p),  c_a_end,  (p >= 4));
         check($sformatf("a188_mid_p%0d", p),  c_a_mid,  0);
         check($sformatf("b188_lock_p%0d", p), c_b_lock, 0);
         if (p == 0) check("a188_byteout_sync", c_a_bo, 8'h47);
      end

      // single corrupt sync: flywheel
      send_pkt(188, 8'hB8);
      check("c1_sync", c_a_sync, 1);
      check("c1_err",  c_a_err, 1);
      check("c1_lock", c_a_lock, 1);
      check("c1_lost", c_a_lost, 0);
      check("c1_cnt",  a_cnt, 1);
      send_pkt(188, 8'h47);
      check("g1_sync", c_a_sync, 1);
      check("g1_err",  c_a_err, 0);

      // three consecutive corrupt syncs (miss was cleared by the good sync)
      for (int p = 0; p < 3; p++) begin
         send_pkt(188, 8'hB8);
         check($sformatf("cm_err_%0d", p),  c_a_err, 1);
         check($sformatf("cm_sync_%0d", p), c_a_sync, (p < 2));
         check($sformatf("cm_lock_%0d", p), c_a_lock, (p < 2));
         check($sformatf("cm_lost_%0d", p), c_a_lost, (p == 2));
         check($sformatf("cm_end_%0d", p),  c_a_end, (p < 2));
      end
      check("cm_cnt", a_cnt, 4);
      check("b_cnt_quiet", b_cnt, 0);

      // random valid gaps: lock timing counted in valid bytes
      do_reset();
      check("rst2_cnt", a_cnt, 0);
      gap_max = 7;
      for (int p = 0; p < 5; p++) begin
         send_pkt(188, 8'h47);
         check($sformatf("gap_lock_p%0d", p), c_a_lock, (p == 4));
         check($sformatf("gap_sync_p%0d", p), c_a_sync, (p == 4));
      end
      gap_max = 0;
      check("gap_quiet", gap_bad, 0);

      // reset mid-packet while locked
      send_byte(8'h47);
      for (int i = 1; i < 60; i++) send_byte(8'((i % 64) + 1));
      check("pre_rst_locked", a_locked, 1);
      rst = 1'b1; byte_valid = 1'b1; byte_in = 8'h47;
      @(posedge clk); #1;
      rst = 1'b0; byte_valid = 1'b0;
      check("mrst_locked",  a_locked, 0);
      check("mrst_valid",   a_valid, 0);
      check("mrst_sync",    a_sync, 0);
      check("mrst_byteout", a_byte_out, 0);
      for (int p = 0; p < 5; p++) begin
         send_pkt(188, 8'h47);
         check($sformatf("relock_p%0d", p), c_a_lock, (p == 4));
      end

      // 204 stream: u_b locks, u_a never does
      do_reset();
      for (int p = 0; p < 6; p++) begin
         send_pkt(204, 8'h47);
         check($sformatf("b204_lock_p%0d", p), c_b_lock, (p >= 4));
         check($sformatf("b204_sync_p%0d", p), c_b_sync, (p >= 4));
         check($sformatf("b204_end_p%0d", p),  c_b_end,  (p >= 4));
         check($sformatf("b204_mid_p%0d", p),  c_b_mid,  0);
         check($sformatf("a204_lock_p%0d", p), c_a_lock, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
